// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction fetch unit.
//   ifu_state_e       - fetch FSM state encoding (FETCH / HOLD)
//   NOP_INSTR         - canonical no-op (addi x0, x0, 0)
//   DEFAULT_RESET_PC  - default first fetch address after reset
//   pc_plus4()        - sequential next PC, wraps modulo 2^32
//   align_word()      - forces a redirect target onto a word boundary
package instruction_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Plain 32-bit add: the carry out is dropped, so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction memory reads and
// fills the IF/ID pipeline register.
//
// Ports
//   CLK, RESETN        - clock (rising edge) and async active-low reset
//   STALL              - decode hazard; holds PC and IF/ID
//   BRANCH_JUMP_TAKEN  - redirect request, overrides everything else
//   BRANCH_JUMP_PC     - redirect target (low two bits are dropped)
//   IMEM_REQ/ADDR      - read request and address (ADDR is the PC flop)
//   IMEM_READY/DATA    - returned word, valid for IMEM_ADDR this cycle
//   IFID_PC/INSTR/VALID- IF/ID pipeline register
//   FLUSH_OUT          - one-cycle pulse after a redirect (kills ID/EX)
//   FETCH_MISALIGN     - one-cycle pulse, aligned with FLUSH_OUT, when the
//                        redirect target was not word aligned
//   dbg_state          - current FSM state, for observation only
//
// Handshake: a memory word is consumed only in a cycle where IMEM_REQ=1
// (state FETCH) and IMEM_READY=1; IMEM_DATA then belongs to IMEM_ADDR.
// A word that is returned while STALL=1 is parked in a one-entry buffer
// (state HOLD, no further requests) and handed to IF/ID on stall release.
// A redirect in the same cycle drops the returned word entirely.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        STALL,
  input  logic        BRANCH_JUMP_TAKEN,
  input  logic [31:0] BRANCH_JUMP_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_INSTR,
  output logic        IFID_VALID,
  output logic        FLUSH_OUT,
  output logic        FETCH_MISALIGN,
  output ifu_state_e  dbg_state
);

  ifu_state_e  state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] ifid_pc_q,    ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] buf_pc_q,     buf_pc_d;
  logic [31:0] buf_instr_q,  buf_instr_d;
  logic        flush_q,      flush_d;
  logic        misalign_q,   misalign_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    flush_d      = 1'b0;
    misalign_d   = 1'b0;

    if (BRANCH_JUMP_TAKEN) begin
      // Redirect wins over stall, memory response and state. Any word
      // arriving this cycle or sitting in the buffer is wrong-path.
      state_d      = FETCH;
      pc_d         = align_word(BRANCH_JUMP_PC);
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      buf_pc_d     = 32'h0;
      buf_instr_d  = 32'h0;
      flush_d      = 1'b1;
      misalign_d   = |BRANCH_JUMP_PC[1:0];
    end else begin
      unique case (state_q)
        FETCH: begin
          if (IMEM_READY) begin
            if (!STALL) begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = IMEM_DATA;
              ifid_valid_d = 1'b1;
              pc_d         = pc_plus4(pc_q);
            end else begin
              // Decode cannot take it yet; park the word and stop fetching.
              buf_pc_d    = pc_q;
              buf_instr_d = IMEM_DATA;
              state_d     = HOLD;
            end
          end else if (!STALL) begin
            ifid_valid_d = 1'b0;  // bubble while memory is busy
          end
        end
        HOLD: begin
          if (!STALL) begin
            ifid_pc_d    = buf_pc_q;
            ifid_instr_d = buf_instr_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4(pc_q);
            state_d      = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      buf_pc_q     <= 32'h0;
      buf_instr_q  <= 32'h0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
    end
  end

  // All outputs come straight from flops.
  assign IMEM_REQ       = (state_q == FETCH);
  assign IMEM_ADDR      = pc_q;
  assign IFID_PC        = ifid_pc_q;
  assign IFID_INSTR     = ifid_instr_q;
  assign IFID_VALID     = ifid_valid_q;
  assign FLUSH_OUT      = flush_q;
  assign FETCH_MISALIGN = misalign_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Instruction memory is modelled
// by imem_word(); IF/ID loads predicted from the stimulus are queued in
// exp_q and popped when the fetch unit is expected to produce them.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK;
  logic        RESETN;
  logic        STALL;
  logic        BRANCH_JUMP_TAKEN;
  logic [31:0] BRANCH_JUMP_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic [31:0] IMEM_DATA;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_INSTR;
  logic        IFID_VALID;
  logic        FLUSH_OUT;
  logic        FETCH_MISALIGN;
  ifu_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected IF/ID contents, {pc, instr}.
  logic [63:0] exp_q[$];

  // Bench-side expectation state.
  logic [31:0] m_pc;
  logic        m_hold;
  logic        m_valid;
  logic [63:0] m_buf;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK               (CLK),
    .RESETN            (RESETN),
    .STALL             (STALL),
    .BRANCH_JUMP_TAKEN (BRANCH_JUMP_TAKEN),
    .BRANCH_JUMP_PC    (BRANCH_JUMP_PC),
    .IMEM_REQ          (IMEM_REQ),
    .IMEM_ADDR         (IMEM_ADDR),
    .IMEM_READY        (IMEM_READY),
    .IMEM_DATA         (IMEM_DATA),
    .IFID_PC           (IFID_PC),
    .IFID_INSTR        (IFID_INSTR),
    .IFID_VALID        (IFID_VALID),
    .FLUSH_OUT         (FLUSH_OUT),
    .FETCH_MISALIGN    (FETCH_MISALIGN),
    .dbg_state         (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Words at 0,4,8 are 0x11,0x22,0x33.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_hold  = 1'b0;
    m_valid = 1'b0;
    m_buf   = 64'h0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  IMEM_ADDR, RST_PC);
    check({tag, "_req"},   32'(IMEM_REQ), 32'd1);
    check({tag, "_pc"},    IFID_PC, 32'h0);
    check({tag, "_instr"}, IFID_INSTR, 32'h0000_0013);
    check({tag, "_valid"}, 32'(IFID_VALID), 32'd0);
    check({tag, "_flush"}, 32'(FLUSH_OUT), 32'd0);
    check({tag, "_mis"},   32'(FETCH_MISALIGN), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(FETCH));
  endtask

  // Driver: apply one cycle of inputs (just after a rising edge), predict
  // the result, clock once, then compare #1 after the next rising edge.
  task automatic step(input string tag, input logic stall, input logic ready,
                      input logic br, input logic [31:0] bpc);
    logic [31:0] word;
    logic        loaded;
    logic [63:0] exp_e;
    word   = imem_word(IMEM_ADDR);
    loaded = 1'b0;
    STALL             = stall;
    IMEM_READY        = ready;
    BRANCH_JUMP_TAKEN = br;
    BRANCH_JUMP_PC    = bpc;
    IMEM_DATA         = ready ? word : $urandom;

    if (br) begin
      m_pc    = {bpc[31:2], 2'b00};
      m_hold  = 1'b0;
      m_valid = 1'b0;
    end else if (!m_hold) begin
      if (ready && !stall) begin
        exp_q.push_back({m_pc, word});
        loaded  = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
      end else if (ready && stall) begin
        m_buf  = {m_pc, word};
        m_hold = 1'b1;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
    end else if (!stall) begin
      exp_q.push_back(m_buf);
      loaded  = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_hold  = 1'b0;
      m_valid = 1'b1;
    end

    @(posedge CLK);
    #1;
    check({tag, "_addr"},  IMEM_ADDR, m_pc);
    check({tag, "_req"},   32'(IMEM_REQ), 32'(!m_hold));
    check({tag, "_valid"}, 32'(IFID_VALID), 32'(m_valid));
    check({tag, "_flush"}, 32'(FLUSH_OUT), 32'(br));
    check({tag, "_mis"},   32'(FETCH_MISALIGN), 32'(br && (bpc[1:0] != 2'b00)));
    if (br) check({tag, "_nop"}, IFID_INSTR, 32'h0000_0013);
    if (loaded) begin
      exp_e = exp_q.pop_front();
      check({tag, "_ifid_pc"},    IFID_PC, exp_e[63:32]);
      check({tag, "_ifid_instr"}, IFID_INSTR, exp_e[31:0]);
    end
  endtask

  initial begin
    RESETN            = 1'b0;
    STALL             = 1'b0;
    IMEM_READY        = 1'b0;
    BRANCH_JUMP_TAKEN = 1'b0;
    BRANCH_JUMP_PC    = 32'h0;
    IMEM_DATA         = 32'h0;
    model_reset();

    // Reset values while held in reset.
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("rst");
    RESETN = 1'b1;
    #1;
    check("post_rst_req",  32'(IMEM_REQ), 32'd1);
    check("post_rst_addr", IMEM_ADDR, RST_PC);

    // Streaming fetch: 0/0x11 then 4/0x22.
    step("seq0", 1'b0, 1'b1, 1'b0, 32'h0);
    check("seq0_word", IFID_INSTR, 32'h11);
    step("seq1", 1'b0, 1'b1, 1'b0, 32'h0);
    check("seq1_word", IFID_INSTR, 32'h22);
    check("seq1_addr8", IMEM_ADDR, 32'h8);

    // Word at 0x8 returns under a 3-cycle stall.
    step("stall0", 1'b1, 1'b1, 1'b0, 32'h0);
    check("stall0_state", 32'(dbg_state), 32'(HOLD));
    step("stall1", 1'b1, 1'b0, 1'b0, 32'h0);
    step("stall2", 1'b1, 1'b1, 1'b0, 32'h0);
    check("stall2_ifid_pc",  IFID_PC, 32'h4);
    check("stall2_ifid_ins", IFID_INSTR, 32'h22);
    check("stall2_req",      32'(IMEM_REQ), 32'd0);
    step("release", 1'b0, 1'b0, 1'b0, 32'h0);
    check("release_pc",    IFID_PC, 32'h8);
    check("release_instr", IFID_INSTR, 32'h33);
    check("release_addr",  IMEM_ADDR, 32'hC);
    check("release_state", 32'(dbg_state), 32'(FETCH));

    // Bubble when memory is not ready, then resume.
    step("bubble", 1'b0, 1'b0, 1'b0, 32'h0);
    step("resume", 1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect with STALL and IMEM_READY both high: word dropped.
    step("br100", 1'b1, 1'b1, 1'b1, 32'h100);
    check("br100_pc", IMEM_ADDR, 32'h100);
    step("br100_after", 1'b0, 1'b0, 1'b0, 32'h0);
    check("br100_drop", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect.
    step("br102", 1'b0, 1'b1, 1'b1, 32'h102);
    check("br102_pc", IMEM_ADDR, 32'h100);
    step("br102_after", 1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect out of HOLD, then back-to-back redirects; last one wins.
    step("hold_br0", 1'b1, 1'b1, 1'b0, 32'h0);
    step("hold_br1", 1'b1, 1'b0, 1'b1, 32'h200);
    step("brbb0", 1'b0, 1'b1, 1'b1, 32'h301);
    step("brbb1", 1'b0, 1'b1, 1'b1, 32'h400);
    check("brbb1_pc", IMEM_ADDR, 32'h400);

    // PC wrap at the top of the address space.
    step("wrap_br", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_pc", IMEM_ADDR, 32'h0000_0000);
    check("wrap_ifid_pc", IFID_PC, 32'hFFFF_FFFC);

    // Reset asserted while in HOLD.
    step("pre_rst_hold", 1'b1, 1'b1, 1'b0, 32'h0);
    check("pre_rst_state", 32'(dbg_state), 32'(HOLD));
    #2;
    RESETN = 1'b0;
    #1;
    check_reset_values("rst_hold");
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    model_reset();
    STALL = 1'b0;
    #1;
    check("rst_hold_addr", IMEM_ADDR, RST_PC);
    step("rst_hold_fetch", 1'b0, 1'b1, 1'b0, 32'h0);
    check("rst_hold_word", IFID_INSTR, 32'h11);

    // Reset asserted during the flush pulse of a redirect.
    step("pre_rst_br", 1'b0, 1'b1, 1'b1, 32'h83);
    #2;
    RESETN = 1'b0;
    #1;
    check_reset_values("rst_br");
    @(posedge CLK);
    #1;
    check("rst_br_no_pulse", 32'(FLUSH_OUT | FETCH_MISALIGN), 32'd0);
    RESETN = 1'b1;
    model_reset();
    BRANCH_JUMP_TAKEN = 1'b0;
    step("rst_br_fetch0", 1'b0, 1'b1, 1'b0, 32'h0);
    step("rst_br_fetch1", 1'b0, 1'b1, 1'b0, 32'h0);

    // Random tail against the expectation state.
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0), $urandom & 32'h0000_0FFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything past this is a hang.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
